// File: rtl/spi_arb_pkg.sv
// Shared definitions for the DAC/register SPI arbiter: chip-select codes,
// grant encoding, FSM state encoding and the delay-counter load helper.
package spi_arb_pkg;

    // Active-low chip-select codes on cs_dac_reg
    localparam logic [1:0] CS_NONE = 2'b11;
    localparam logic [1:0] CS_DAC  = 2'b01;
    localparam logic [1:0] CS_REG  = 2'b10;

    // Grant encoding, also used for last_grant
    localparam logic GRANT_DAC = 1'b0;
    localparam logic GRANT_REG = 1'b1;

    // Width of the setup/hold/gap delay counter
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // HOLD and GAP leave on the zero flag, so a span of N cycles loads N-1.
    // A span of 0 still costs the one cycle spent in the state.
    function automatic logic [CNT_W-1:0] span_load(input int cycles);
        if (cycles <= 1) return '0;
        else             return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_arb_delay_cnt.sv
// Loadable 4-bit down-counter with a zero flag; shared by the setup, hold
// and gap phases of the arbiter (only one phase is ever active).
import spi_arb_pkg::*;

module spi_arb_delay_cnt (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt <= '0;
        else if (load)               cnt <= load_val;
        else if (dec && cnt != '0)   cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spi_dac_reg_arbiter.sv
// Arbiter sharing one SPI master between the DAC sample path and the
// range/key register writer. Round-robin on ties, CS setup/hold/gap timing,
// all outputs registered.
// Optional watchdog on the WAIT state: define SPI_ARB_TIMEOUT_EN.
import spi_arb_pkg::*;

module spi_dac_reg_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int CS_SETUP       = 1,
    parameter int CS_HOLD        = 1,
    parameter int CS_GAP         = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dac_req,
    input  logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_ack,
    input  logic                  reg_req,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic                  reg_ack,
    output logic                  spi_start,
    output logic [DATA_WIDTH-1:0] spi_data_out,
    input  logic                  spi_busy,
    input  logic                  spi_new_data,
    output logic [1:0]            cs_dac_reg,
    output logic                  timeout
);

    state_t                state, state_nxt;
    logic                  grant, grant_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [1:0]            cs_nxt;
    logic                  start_nxt, dac_ack_nxt, reg_ack_nxt;
    logic                  pick;

    logic                  cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]      cnt_val;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            to_nxt;

    // Watchdog counts cycles spent in WAIT and saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  wd_cnt <= '0;
        else if (state != ST_WAIT)                wd_cnt <= '0;
        else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
    end

    // Last WAIT cycle before expiry; timeout pulses on the following cycle
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Registered one-cycle timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout <= 1'b0;
        else     timeout <= to_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

    spi_arb_delay_cnt u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant        <= GRANT_DAC;
            last_grant   <= GRANT_REG;
            spi_data_out <= '0;
            cs_dac_reg   <= CS_NONE;
            spi_start    <= 1'b0;
            dac_ack      <= 1'b0;
            reg_ack      <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            last_grant   <= last_grant_nxt;
            spi_data_out <= data_nxt;
            cs_dac_reg   <= cs_nxt;
            spi_start    <= start_nxt;
            dac_ack      <= dac_ack_nxt;
            reg_ack      <= reg_ack_nxt;
        end
    end

    // Next-state, next-output and delay-counter control
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        data_nxt       = spi_data_out;
        cs_nxt         = cs_dac_reg;
        start_nxt      = 1'b0;
        dac_ack_nxt    = 1'b0;
        reg_ack_nxt    = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_val        = '0;
        pick           = GRANT_DAC;
`ifdef SPI_ARB_TIMEOUT_EN
        to_nxt         = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!spi_busy && (dac_req || reg_req)) begin
                    // Tie goes to whoever was not served last
                    if (dac_req && reg_req) pick = ~last_grant;
                    else                    pick = reg_req ? GRANT_REG : GRANT_DAC;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    data_nxt       = (pick == GRANT_REG) ? reg_data : dac_data;
                    cs_nxt         = (pick == GRANT_REG) ? CS_REG : CS_DAC;
                    cnt_load       = 1'b1;
                    cnt_val        = CNT_W'(CS_SETUP);
                    state_nxt      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    start_nxt = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_new_data) begin
                    dac_ack_nxt = (grant == GRANT_DAC);
                    reg_ack_nxt = (grant == GRANT_REG);
                    cnt_load    = 1'b1;
                    cnt_val     = span_load(CS_HOLD);
                    state_nxt   = ST_HOLD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    // Abandon the transfer without an ack; last_grant already moved on
                    to_nxt    = 1'b1;
                    cs_nxt    = CS_NONE;
                    cnt_load  = 1'b1;
                    cnt_val   = span_load(CS_GAP);
                    state_nxt = ST_GAP;
                end
`endif
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cs_nxt    = CS_NONE;
                    cnt_load  = 1'b1;
                    cnt_val   = span_load(CS_GAP);
                    state_nxt = ST_GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) state_nxt = ST_IDLE;
                else          cnt_dec   = 1'b1;
            end
            default: begin
                cs_nxt    = CS_NONE;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_dac_reg_arbiter.sv
// Scoreboard bench for spi_dac_reg_arbiter (default timing 1/1/1).
// Stimulus pushes expected events (CS change, start+data, acks, timeout)
// tagged with the cycle they must appear in; a negedge monitor pops them.
// Build with SPI_ARB_TIMEOUT_EN to also exercise the watchdog (limit 20).
module tb_spi_dac_reg_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 255;
`endif

    localparam int EV_CS = 0, EV_START = 1, EV_DACK = 2, EV_RACK = 3, EV_TO = 4;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dac_req, reg_req, spi_busy, spi_new_data;
    logic [7:0] dac_data, reg_data;
    logic       dac_ack, reg_ack, spi_start, timeout;
    logic [7:0] spi_data_out;
    logic [1:0] cs_dac_reg;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  sbq[$];
    logic [1:0] prev_cs = 2'b11;

    spi_dac_reg_arbiter #(
        .DATA_WIDTH(8), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .dac_req(dac_req), .dac_data(dac_data), .dac_ack(dac_ack),
        .reg_req(reg_req), .reg_data(reg_data), .reg_ack(reg_ack),
        .spi_start(spi_start), .spi_data_out(spi_data_out),
        .spi_busy(spi_busy), .spi_new_data(spi_new_data),
        .cs_dac_reg(cs_dac_reg), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_CS:    return "cs_change";
            EV_START: return "spi_start";
            EV_DACK:  return "dac_ack";
            EV_RACK:  return "reg_ack";
            default:  return "timeout";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [7:0] val, input int at);
        ev_t e;
        e.kind = kind; e.val = val; e.at = at;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic [7:0] val);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got val=%02h at cycle %0d, none expected", kname(kind), val, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.val != val || e.at != cyc) begin
                failures++;
                $display("FAIL %s: got %s val=%02h cycle=%0d, want %s val=%02h cycle=%0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.at);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: every observable DUT event must match the head of the queue
    always @(negedge clk) begin
        if (rst) begin
            prev_cs = cs_dac_reg;
        end else begin
            if (cs_dac_reg != prev_cs) begin
                sb_check(EV_CS, {6'b0, cs_dac_reg});
                prev_cs = cs_dac_reg;
            end
            if (spi_start) sb_check(EV_START, spi_data_out);
            if (dac_ack)   sb_check(EV_DACK, 8'h00);
            if (reg_ack)   sb_check(EV_RACK, 8'h00);
            if (timeout)   sb_check(EV_TO, 8'h00);
        end
    end

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at the negedge of the IDLE cycle in which the request is visible
    // (cycle 0). Expects CS at 1, start at 3, ack at nd+1, CS release at nd+2.
    // Corrupts the granted data after the grant, pulses a stray spi_new_data
    // at offset 'stray' (-1 none), drops the req at offset 'drop'.
    task automatic run_xfer(input logic is_reg, input logic [7:0] data,
                            input int nd, input int stray, input int drop);
        int c0;
        c0 = cyc;
        expect_ev(EV_CS, is_reg ? 8'h02 : 8'h01, c0 + 1);
        expect_ev(EV_START, data, c0 + 3);
        expect_ev(is_reg ? EV_RACK : EV_DACK, 8'h00, c0 + nd + 1);
        expect_ev(EV_CS, 8'h03, c0 + nd + 2);
        for (int k = 0; k <= nd + 3; k++) begin
            at_cycle(c0 + k);
            spi_new_data = (k == nd) || (k == stray);
            if (k == 1) begin
                if (is_reg) reg_data = ~data;
                else        dac_data = ~data;
            end
            if (k == drop) begin
                if (is_reg) reg_req = 1'b0;
                else        dac_req = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        dac_req = 0; reg_req = 0; spi_busy = 0; spi_new_data = 0;
        dac_data = 8'h00; reg_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_cs", cs_dac_reg, 3);
        check("reset_start", spi_start, 0);
        check("reset_data", spi_data_out, 0);
        check("reset_dac_ack", dac_ack, 0);
        check("reset_reg_ack", reg_ack, 0);
        check("reset_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single DAC request, spi_new_data in cycle 10
        dac_data = 8'hA5; dac_req = 1'b1;
        run_xfer(1'b0, 8'hA5, 10, -1, 12);

        // Stray spi_new_data while idle: no events expected
        spi_new_data = 1'b1;
        repeat (2) @(negedge clk);
        spi_new_data = 1'b0;
        @(negedge clk);

        // Ties from reset: DAC, REG, DAC, REG
        apply_reset();
        dac_data = 8'h11; reg_data = 8'h22; dac_req = 1'b1; reg_req = 1'b1;
        run_xfer(1'b0, 8'h11, 6, -1, 8);
        dac_data = 8'h33; dac_req = 1'b1;
        run_xfer(1'b1, 8'h22, 6, -1, 8);
        reg_data = 8'h44; reg_req = 1'b1;
        run_xfer(1'b0, 8'h33, 6, -1, 8);
        run_xfer(1'b1, 8'h44, 5, 2, 7);   // stray spi_new_data in SETUP

        // Busy gating, then req dropped mid-WAIT still gets its ack
        spi_busy = 1'b1; reg_data = 8'h5C; reg_req = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_cs_none", cs_dac_reg, 3);
        check("busy_no_event", sbq.size(), 0);
        spi_busy = 1'b0;
        run_xfer(1'b1, 8'h5C, 7, -1, 5);

        // Async reset in WAIT with REG pending: DAC must win afterwards
        dac_data = 8'h6E; dac_req = 1'b1;
        c0 = cyc;
        expect_ev(EV_CS, 8'h01, c0 + 1);
        expect_ev(EV_START, 8'h6E, c0 + 3);
        at_cycle(c0 + 5);
        reg_data = 8'h7F; reg_req = 1'b1;
        at_cycle(c0 + 6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cs", cs_dac_reg, 3);
        check("async_rst_start", spi_start, 0);
        check("async_rst_data", spi_data_out, 0);
        check("async_rst_acks", {dac_ack, reg_ack}, 0);
        at_cycle(c0 + 8);
        rst = 1'b0;
        run_xfer(1'b0, 8'h6E, 6, -1, 8);
        run_xfer(1'b1, 8'h7F, 6, -1, 8);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: DAC wins tie, times out after 20 WAIT cycles, REG next
        dac_data = 8'h81; reg_data = 8'h92; dac_req = 1'b1; reg_req = 1'b1;
        c0 = cyc;
        expect_ev(EV_CS, 8'h01, c0 + 1);
        expect_ev(EV_START, 8'h81, c0 + 3);
        expect_ev(EV_CS, 8'h03, c0 + 24);
        expect_ev(EV_TO, 8'h00, c0 + 24);
        at_cycle(c0 + 25);
        run_xfer(1'b1, 8'h92, 6, -1, 8);
        run_xfer(1'b0, 8'h81, 6, -1, 8);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_dac_reg_arbiter.md
Name: spi_dac_reg_arbiter

Overview:
- Shares the single DAC/register SPI master between two requesters: the sine-generator DAC sample path and the range/key register writer.
- Owns the 2-bit chip-select bus cs_dac_reg, the SPI start pulse and the transmit byte.
- Enforces CS setup/hold/gap timing and round-robin fairness, so the measurement FSM and the sample path never drive the SPI master directly.

Parameters:
- DATA_WIDTH, 8, width of a transfer word and of the spi_data_out bus.
- CS_SETUP, 1, cycles CS is held before spi_start is pulsed; range 0..15.
- CS_HOLD, 1, cycles CS stays asserted after spi_new_data; range 0..15.
- CS_GAP, 1, idle cycles with CS = none between transfers; range 1..15, 0 is illegal.
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dac_req  in  1  DAC sample transfer request, level.
- dac_data  in  DATA_WIDTH  DAC sample; must stay stable while dac_req is high.
- dac_ack  out  1  one-cycle pulse when the DAC transfer completes.
- reg_req  in  1  register write request, level.
- reg_data  in  DATA_WIDTH  register byte {diap, keys}.
- reg_ack  out  1  one-cycle pulse when the register transfer completes.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_data_out  out  DATA_WIDTH  byte presented to the SPI master.
- spi_busy  in  1  SPI master busy.
- spi_new_data  in  1  SPI master transfer-complete pulse.
- cs_dac_reg  out  2  active-low selects: 2'b11 none, 2'b01 DAC, 2'b10 REG.
- timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 without SPI_ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - state IDLE, cs_dac_reg=2'b11, spi_start=0, spi_data_out=0.
  - dac_ack=0, reg_ack=0, timeout=0, last_grant=REG, so the first tie goes to DAC.
- All outputs are registered.
- States: IDLE, SETUP, START, WAIT, HOLD, GAP.
- IDLE: a request is sampled only when spi_busy=0.
  - One request pending: grant it.
  - Both pending: grant the requester that is not last_grant (round-robin).
  - On the following edge: latch the granted data into spi_data_out, drive the matching CS code, load the counter with CS_SETUP, update last_grant, go to SETUP.
- SETUP: decrement the counter each cycle; at 0 go to START. With CS_SETUP=0, SETUP lasts exactly one cycle.
- START: spi_start=1 for exactly one cycle, then WAIT.
- WAIT: on spi_new_data, pulse the granted ack next cycle, load CS_HOLD, go to HOLD. Any other input is ignored.
- HOLD: count down CS_HOLD cycles, then cs_dac_reg=2'b11, load CS_GAP, go to GAP.
- GAP: count down to 0, then IDLE.
- Latency example (CS_SETUP=1, CS_HOLD=1, CS_GAP=1): dac_req seen at cycle 0 -> CS=01 at cycle 1 -> spi_start at cycle 3 -> ack one cycle after spi_new_data.
- A requester must drop req in the cycle after its ack. Because CS_GAP>=1, the arbiter never samples a stale req.
- Req dropped mid-transfer: the transfer still completes and the ack is still issued.
- req or data changing after grant has no effect; the data was latched at grant.
- spi_new_data outside WAIT: ignored, no ack.
- spi_start is never issued while CS=11.
- The CS code never changes between START and the end of HOLD.
- Counters are 4-bit. The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - WAIT counts cycles. When the count reaches TIMEOUT_CYCLES with no spi_new_data, timeout pulses one cycle.
  - No ack is issued; the arbiter goes directly to GAP with cs_dac_reg=11.
  - last_grant still updates, so the other requester gets the next turn.
- Not defined: WAIT waits indefinitely, timeout is tied 0, and no watchdog counter is synthesised.

Decomposition:
- Package spi_arb_pkg:
  - CS codes: CS_NONE=2'b11, CS_DAC=2'b01, CS_REG=2'b10.
  - State encoding localparams.
  - Grant encoding: GRANT_DAC=0, GRANT_REG=1.
- Sub-module spi_arb_delay_cnt: loadable 4-bit down-counter with a zero flag. It is reused for setup, hold and gap. Everything else is inline.

Test Plan:
- Single DAC request: dac_req=1, dac_data=8'hA5, defaults -> cs=01 at cycle 1, spi_data_out=A5, spi_start at cycle 3; spi_new_data at cycle 10 -> dac_ack at cycle 11, cs=11 at cycle 12, IDLE at cycle 13.
- Simultaneous requests from reset: dac_req and reg_req both high -> DAC served first (cs=01), then REG (cs=10, data=reg_data). Held high again -> order alternates DAC, REG, DAC.
- Busy gating: spi_busy=1 with reg_req=1 for 5 cycles -> cs stays 11 and no start; spi_busy falls -> grant on the next edge.
- Async reset mid-WAIT: rst asserted between clock edges -> cs=11, spi_start=0, acks=0 immediately. After release, a pending request is re-arbitrated with DAC priority.
- Stray spi_new_data in IDLE or SETUP -> no ack, no state change. Req dropped during WAIT -> ack still issued.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20 and no spi_new_data -> timeout pulse after 20 WAIT cycles, no ack, cs=11. The next tie is granted to the other requester.
